cdb_arbiter: RTL
================

CDB_ARBITER -- requirements
Module: cdb_arbiter

Interface
REQ-001 SHALL have parameter DATA_W, default 32: width of the result value.
REQ-002 SHALL have parameter PREG_W, default 6: width of the physical destination register.
REQ-003 SHALL have parameter ROB_W, default 6: width of the ROB index.
REQ-004 SHALL have port `clk`, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 SHALL have port `reset_n`, input, 1 bit: asynchronous, active-low reset.
REQ-006 SHALL have port `flush`, input, 1 bit: synchronous discard of all pending and in-flight results.
REQ-007 SHALL have port `req_valid`, input, 4 bits: per-requester result valid; 0–2 are functional units 0–2, 3 is the load/store unit.
REQ-008 SHALL have port `req_ready`, output, 4 bits: per-requester accept.
REQ-009 SHALL have port `req_dest`, input, 4×PREG_W: per-requester physical destination.
REQ-010 SHALL have port `req_rob_idx`, input, 4×ROB_W: per-requester ROB index.
REQ-011 SHALL have port `req_value`, input, 4×DATA_W: per-requester result.
REQ-012 SHALL have port `cdb_valid`, output, 2 bits: broadcast slot valid, registered.
REQ-013 SHALL have port `cdb_dest`, output, 2×PREG_W: broadcast physical destination, registered.
REQ-014 SHALL have port `cdb_rob_idx`, output, 2×ROB_W: broadcast ROB index, feeding the ROB writeback ports; registered.
REQ-015 SHALL have port `cdb_value`, output, 2×DATA_W: broadcast value, feeding issue-queue wakeup and the ROB; registered.

Function
REQ-016 SHALL hold one holding register plus a pending bit per requester.
REQ-017 SHALL load holding register i and set pending[i] at a rising edge where req_valid[i] && req_ready[i].
REQ-018 SHALL drive req_ready[i] = !flush && (!pending[i] || grant[i]).
REQ-019 req_ready SHALL depend only on state and flush, never on req_valid; this keeps the handshake free of combinational loops.
REQ-020 SHALL grant up to 2 pending entries per cycle, in round-robin order starting at pointer rr_ptr (2 bits).
REQ-021 The first grant SHALL go to slot 0 and the second grant to slot 1.
REQ-022 When one entry is granted, it SHALL go to slot 0 and cdb_valid[1] SHALL be 0 at the next edge.
REQ-023 SHALL register granted entries onto the cdb_* outputs at the next edge.
REQ-024 cdb_valid for a slot with no grant SHALL be 0 at that edge.
REQ-025 SHALL leave cdb data fields unchanged when the slot is not granted.
REQ-026 Minimum latency from request acceptance (edge E) to cdb_valid high SHALL be one further edge (E+1), i.e. 2 cycles from req_valid assertion.
REQ-027 When a granted requester is refilled in the same cycle, its pending bit SHALL stay 1 with the new data (back-to-back throughput of 1 result per requester per cycle).
REQ-028 Granted requesters that are not refilled SHALL clear their pending bit.
REQ-029 rr_ptr SHALL advance to (index of last granted requester + 1) mod 4, and SHALL hold when there are no grants.
REQ-030 With 3 or 4 requests pending, every pending entry SHALL be granted within 2 cycles (starvation-free).
REQ-031 flush=1 SHALL clear all pending bits and both cdb_valid bits at the next edge.
REQ-032 flush=1 SHALL leave rr_ptr unchanged.
REQ-033 flush=1 SHALL hold req_ready at 0, so no acceptance occurs; flush wins over a simultaneous request.
REQ-034 SHALL pass req_dest = 0 (no-destination instruction, e.g. a store) through unchanged; it is not filtered.
REQ-035 The two cdb slots SHALL never carry the same requester in one cycle.

Reset
REQ-036 While reset_n = 0, SHALL asynchronously clear pending[3:0] to 0.
REQ-037 While reset_n = 0, SHALL asynchronously clear rr_ptr to 0.
REQ-038 While reset_n = 0, SHALL asynchronously clear cdb_valid to 0.
REQ-039 While reset_n = 0, SHALL asynchronously clear cdb_dest, cdb_rob_idx and cdb_value to 0.
REQ-040 While reset_n = 0, req_ready SHALL read 4'b1111, provided flush = 0.
REQ-041 Reset asserted mid-operation SHALL drop all held results without broadcast.

Structure
REQ-042 A shared package cdb_pkg SHALL hold NUM_REQ = 4, NUM_CDB = 2, the DATA_W/PREG_W/ROB_W defaults and a packed cdb_entry_t type (dest, rob_idx, value).
REQ-043 One combinational sub-module, cdb_rr_select, SHALL take pending[3:0] and rr_ptr.
REQ-044 cdb_rr_select SHALL return grant0/grant1 one-hot vectors, their valid bits and the next rr_ptr.

Verification
REQ-045 Reset scenario: after reset release, cdb_valid = 0, req_ready = 4'hF, and rr_ptr = 0 (observed via the grant order of test 2).
REQ-046 All-pending scenario: all 4 req_valid high for one cycle (values 0x10–0x13, rob 1–4). Cycle +1 SHALL broadcast requesters 0 (slot 0) and 1 (slot 1); cycle +2 SHALL broadcast requesters 2 and 3; req_ready[2] = req_ready[3] = 0 until granted.
REQ-047 Streaming scenario: FU0 holds req_valid continuously with an incrementing value. One result SHALL appear per cycle on a cdb slot with no gaps, and req_ready[0] SHALL stay 1.
REQ-048 Round-robin scenario: FU0–FU2 and the LSU are saturated for 8 cycles. Each requester SHALL receive exactly 4 grants, and no two consecutive grant pairs SHALL be identical.
REQ-049 Flush scenario: flush is asserted while 3 entries are pending and a new req_valid[3] arrives. The next edge SHALL give cdb_valid = 0 and pending = 0, and the LSU result SHALL not be accepted (req_ready[3] = 0).
REQ-050 Mid-stream reset scenario: reset_n is pulsed low between edges with 2 entries pending. Outputs SHALL clear immediately, and no stale broadcast SHALL appear after release.

Source files
------------

// File: rtl/cdb_pkg.sv
// Shared constants and payload type for the common-data-bus arbiter.
package cdb_pkg;

    localparam int unsigned NUM_REQ    = 4;
    localparam int unsigned NUM_CDB    = 2;
    localparam int unsigned RR_W       = $clog2(NUM_REQ);
    localparam int unsigned DEF_DATA_W = 32;
    localparam int unsigned DEF_PREG_W = 6;
    localparam int unsigned DEF_ROB_W  = 6;

    typedef struct packed {
        logic [DEF_PREG_W-1:0] dest;
        logic [DEF_ROB_W-1:0]  rob_idx;
        logic [DEF_DATA_W-1:0] value;
    } cdb_entry_t;

endpackage

// File: rtl/cdb_rr_select.sv
// Round-robin picker: up to two pending requesters starting at rr_ptr.
module cdb_rr_select
    import cdb_pkg::*;
(
    input  logic [NUM_REQ-1:0] pending,
    input  logic [RR_W-1:0]    rr_ptr,
    output logic [NUM_REQ-1:0] grant0_c,
    output logic [NUM_REQ-1:0] grant1_c,
    output logic               grant0_valid_c,
    output logic               grant1_valid_c,
    output logic [RR_W-1:0]    rr_ptr_next_c
);

    logic [RR_W-1:0] idx;

    // Scan in rotated order; the later of the two grants sets the next pointer.
    always_comb begin
        grant0_c       = '0;
        grant1_c       = '0;
        grant0_valid_c = 1'b0;
        grant1_valid_c = 1'b0;
        rr_ptr_next_c  = rr_ptr;
        idx            = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            idx = rr_ptr + RR_W'(i);
            if (pending[idx]) begin
                if (!grant0_valid_c) begin
                    grant0_c[idx]  = 1'b1;
                    grant0_valid_c = 1'b1;
                    rr_ptr_next_c  = idx + RR_W'(1);
                end else if (!grant1_valid_c) begin
                    grant1_c[idx]  = 1'b1;
                    grant1_valid_c = 1'b1;
                    rr_ptr_next_c  = idx + RR_W'(1);
                end
            end
        end
    end

endmodule

// File: rtl/cdb_arbiter.sv
// Collects results from three FUs and the LSU into per-requester holding
// registers and broadcasts up to two of them per cycle on the CDB.
module cdb_arbiter
    import cdb_pkg::*;
#(
    parameter int unsigned DATA_W = DEF_DATA_W,
    parameter int unsigned PREG_W = DEF_PREG_W,
    parameter int unsigned ROB_W  = DEF_ROB_W
)
(
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic                        flush,
    input  logic [NUM_REQ-1:0]          req_valid,
    output logic [NUM_REQ-1:0]          req_ready,
    input  logic [NUM_REQ*PREG_W-1:0]   req_dest,
    input  logic [NUM_REQ*ROB_W-1:0]    req_rob_idx,
    input  logic [NUM_REQ*DATA_W-1:0]   req_value,
    output logic [NUM_CDB-1:0]          cdb_valid,
    output logic [NUM_CDB*PREG_W-1:0]   cdb_dest,
    output logic [NUM_CDB*ROB_W-1:0]    cdb_rob_idx,
    output logic [NUM_CDB*DATA_W-1:0]   cdb_value
);

    typedef struct packed {
        logic [PREG_W-1:0] dest;
        logic [ROB_W-1:0]  rob_idx;
        logic [DATA_W-1:0] value;
    } entry_t;

    logic   [NUM_REQ-1:0] pending_q, pending_d;
    entry_t [NUM_REQ-1:0] hold_q, hold_d;
    entry_t [NUM_REQ-1:0] req_c;
    logic   [RR_W-1:0]    rr_ptr_q, rr_ptr_d, rr_ptr_next_c;
    logic   [NUM_CDB-1:0] cdb_valid_q, cdb_valid_d;
    entry_t [NUM_CDB-1:0] cdb_q, cdb_d;
    logic   [NUM_REQ-1:0] grant0_c, grant1_c, accept_c;
    logic                 grant0_valid_c, grant1_valid_c;
    entry_t               sel0_c, sel1_c;

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_req
        assign req_c[i].dest    = req_dest[i*PREG_W +: PREG_W];
        assign req_c[i].rob_idx = req_rob_idx[i*ROB_W +: ROB_W];
        assign req_c[i].value   = req_value[i*DATA_W +: DATA_W];
    end

    for (genvar s = 0; s < NUM_CDB; s++) begin : g_cdb
        assign cdb_dest[s*PREG_W +: PREG_W]   = cdb_q[s].dest;
        assign cdb_rob_idx[s*ROB_W +: ROB_W]  = cdb_q[s].rob_idx;
        assign cdb_value[s*DATA_W +: DATA_W]  = cdb_q[s].value;
    end
    assign cdb_valid = cdb_valid_q;

    cdb_rr_select u_rr_select (
        .pending        (pending_q),
        .rr_ptr         (rr_ptr_q),
        .grant0_c       (grant0_c),
        .grant1_c       (grant1_c),
        .grant0_valid_c (grant0_valid_c),
        .grant1_valid_c (grant1_valid_c),
        .rr_ptr_next_c  (rr_ptr_next_c)
    );

    // Ready is a function of state and flush only, so no loop through req_valid.
    assign req_ready = {NUM_REQ{!flush}} & (~pending_q | grant0_c | grant1_c);
    assign accept_c  = req_valid & req_ready;

    always_comb begin
        sel0_c = '0;
        sel1_c = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant0_c[i]) sel0_c = hold_q[i];
            if (grant1_c[i]) sel1_c = hold_q[i];
        end
    end

    always_comb begin
        pending_d   = pending_q;
        hold_d      = hold_q;
        rr_ptr_d    = rr_ptr_q;
        cdb_valid_d = '0;
        cdb_d       = cdb_q;
        if (flush) begin
            pending_d = '0;
        end else begin
            pending_d = (pending_q & ~(grant0_c | grant1_c)) | accept_c;
            for (int i = 0; i < NUM_REQ; i++) begin
                if (accept_c[i]) hold_d[i] = req_c[i];
            end
            cdb_valid_d = {grant1_valid_c, grant0_valid_c};
            if (grant0_valid_c) cdb_d[0] = sel0_c;
            if (grant1_valid_c) cdb_d[1] = sel1_c;
            rr_ptr_d = rr_ptr_next_c;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pending_q   <= '0;
            hold_q      <= '0;
            rr_ptr_q    <= '0;
            cdb_valid_q <= '0;
            cdb_q       <= '0;
        end else begin
            pending_q   <= pending_d;
            hold_q      <= hold_d;
            rr_ptr_q    <= rr_ptr_d;
            cdb_valid_q <= cdb_valid_d;
            cdb_q       <= cdb_d;
        end
    end

endmodule
